// File: rtl/frame_pkg.sv
// Shared constants, FSM state encoding and checksum helper for the frame dispatcher.
package frame_pkg;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  localparam int CHK_SUM = 0;
  localparam int CHK_XOR = 1;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    CMD,
    LENH,
    LENL,
    PAY,
    CHK,
    DELIVER
  } state_t;

  function automatic logic [7:0] chk_update(input int mode, input logic [7:0] acc,
                                            input logic [7:0] b);
    return (mode == CHK_XOR) ? (acc ^ b) : (acc + b);
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Simple dual-port payload store: one write port, one read port with registered data.
module frame_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_dispatch.sv
// Parses AA 55 CMD LEN_H LEN_L PAYLOAD CHK frames, validates them, then replays the
// buffered payload on a valid/ready stream behind a one-cycle header strobe.
module frame_dispatch
  import frame_pkg::*;
#(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] CMD_BASE    = 8'h04,
  parameter int         MAX_LEN     = 256,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CHK_MODE    = CHK_SUM,
  localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            hdr_valid,
  output logic [CH_W-1:0] hdr_ch,
  output logic [15:0]     hdr_len,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            err_chk,
  output logic            err_len,
  output logic            err_cmd,
  output logic            err_tmo,
  output state_t          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holding valid keeps its data stable until that edge.

  localparam int          ABW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          PW        = $clog2(MAX_LEN + 1);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [8:0]  CMD_END   = 9'(CMD_BASE) + 9'(NUM_CH);

  state_t            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        lenh_q, lenh_d;
  logic [15:0]       len_q, len_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              in_ready_q, in_ready_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic [CH_W-1:0]   hdr_ch_q, hdr_ch_d;
  logic [15:0]       hdr_len_q, hdr_len_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              err_chk_q, err_chk_d;
  logic              err_len_q, err_len_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_tmo_q, err_tmo_d;

  logic              accept, pipe_adv, in_frame, cmd_bad;
  logic [7:0]        chk_next;
  logic              wr_en, rd_en;
  logic [ABW-1:0]    rd_addr;
  logic [7:0]        rd_data;

  assign accept   = in_valid && in_ready_q;
  assign pipe_adv = !out_valid_q || out_ready;
  assign in_frame = (state_q != IDLE) && (state_q != DELIVER);
  assign chk_next = chk_update(CHK_MODE, chk_q, in_data);
  assign cmd_bad  = (cmd_q < CMD_BASE) || ({1'b0, cmd_q} >= CMD_END);

  frame_buf #(.DEPTH(MAX_LEN), .AW(ABW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (ptr_q[ABW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    lenh_d      = lenh_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    chk_d       = chk_q;
    tmo_d       = 32'd0;
    hdr_valid_d = 1'b0;
    hdr_ch_d    = hdr_ch_q;
    hdr_len_d   = hdr_len_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_cmd_d   = 1'b0;
    err_tmo_d   = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = ptr_q[ABW-1:0];

    if (in_frame && !accept) tmo_d = tmo_q + 32'd1;

    case (state_q)
      IDLE: if (accept && in_data == SYNC0) state_d = SYNC;
      SYNC: if (accept) begin
        if (in_data == SYNC1)      state_d = CMD;
        else if (in_data != SYNC0) state_d = IDLE;
      end
      CMD: if (accept) begin
        cmd_d   = in_data;
        chk_d   = chk_update(CHK_MODE, 8'h00, in_data);
        state_d = LENH;
      end
      LENH: if (accept) begin
        lenh_d  = in_data;
        chk_d   = chk_next;
        state_d = LENL;
      end
      LENL: if (accept) begin
        len_d = {lenh_q, in_data};
        chk_d = chk_next;
        ptr_d = '0;
        if ({lenh_q, in_data} > MAX_LEN16) begin
          err_len_d = 1'b1;
          state_d   = IDLE;
        end else if ({lenh_q, in_data} == 16'd0) begin
          state_d = CHK;
        end else begin
          state_d = PAY;
        end
      end
      PAY: if (accept) begin
        wr_en = 1'b1;
        chk_d = chk_next;
        ptr_d = ptr_q + 1'b1;
        if (16'(ptr_q) == len_q - 16'd1) state_d = CHK;
      end
      CHK: if (accept) begin
        if (in_data != chk_q) begin
          err_chk_d = 1'b1;
          state_d   = IDLE;
        end else if (cmd_bad) begin
          err_cmd_d = 1'b1;
          state_d   = IDLE;
        end else begin
          hdr_valid_d = 1'b1;
          hdr_ch_d    = CH_W'(cmd_q - CMD_BASE);
          hdr_len_d   = len_q;
          if (len_q == 16'd0) begin
            state_d = IDLE;
          end else begin
            // Prefetch byte 0 during the header cycle so out_valid can follow it directly.
            rd_en      = 1'b1;
            rd_addr    = '0;
            ptr_d      = PW'(1);
            s1_valid_d = 1'b1;
            s1_last_d  = (len_q == 16'd1);
            state_d    = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (pipe_adv) begin
          out_valid_d = s1_valid_q;
          out_data_d  = rd_data;
          out_last_d  = s1_last_q;
          s1_valid_d  = 1'b0;
        end
        // The RAM output register is a pipeline stage; refill it whenever it drains.
        if ((pipe_adv || !s1_valid_q) && (16'(ptr_q) < len_q)) begin
          rd_en      = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          s1_valid_d = 1'b1;
          s1_last_d  = (16'(ptr_q) == len_q - 16'd1);
        end
        if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (in_frame && !accept && tmo_q == TMO_LAST) begin
      err_tmo_d = 1'b1;
      state_d   = IDLE;
    end

    in_ready_d = (state_d != DELIVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      lenh_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b1;
      hdr_valid_q <= 1'b0;
      hdr_ch_q    <= '0;
      hdr_len_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      lenh_q      <= lenh_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_ch_q    <= hdr_ch_d;
      hdr_len_q   <= hdr_len_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_cmd_q   <= err_cmd_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign hdr_valid = hdr_valid_q;
  assign hdr_ch    = hdr_ch_q;
  assign hdr_len   = hdr_len_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign err_chk   = err_chk_q;
  assign err_len   = err_len_q;
  assign err_cmd   = err_cmd_q;
  assign err_tmo   = err_tmo_q;
  assign dbg_state = state_q;

endmodule
